// File: rtl/frame_timer_pkg.sv
// Shared types and default constants for the frame-based playback timer.
package frame_timer_pkg;

    typedef enum logic [1:0] {
        HALTED = 2'd0,
        RUN    = 2'd1,
        PAUSE  = 2'd2,
        DONE   = 2'd3
    } timer_state_t;

    localparam int FT_DEF_WIDTH = 16;
    localparam int FT_DEF_END   = 5669;
    localparam int FT_DEF_DONE  = 5680;
    localparam int FT_DEF_SYNC  = 2;

endpackage

// File: rtl/frame_edge_sync.sv
// Synchronizes the asynchronous frame strobe and emits a one-cycle pulse
// (fp) on each synchronized rising edge.
module frame_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic new_frame,
    output logic fp
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_fp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_fp   <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], new_frame};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_fp   <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign fp = r_fp;

endmodule

// File: rtl/frame_timer.sv
// Frame-counting playback timer with start/abort and end-of-song latch.
// Pause support is built only when FRAME_TIMER_PAUSE_EN is defined.
module frame_timer
    import frame_timer_pkg::*;
#(
    parameter int WIDTH       = FT_DEF_WIDTH,
    parameter int END_COUNT   = FT_DEF_END,
    parameter int DONE_VALUE  = FT_DEF_DONE,
    parameter int SYNC_STAGES = FT_DEF_SYNC
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_sign,
    input  logic             pause_sign,
    input  logic             abort_sign,
    input  logic             new_frame,
    output logic             stop_sign,
    output logic             running,
    output logic             frame_tick,
    output logic [WIDTH-1:0] un_time
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("frame_timer: SYNC_STAGES must be at least 2");
    end
    if (longint'(END_COUNT) >= (longint'(1) << WIDTH)) begin : g_bad_end
        $error("frame_timer: END_COUNT does not fit in WIDTH bits");
    end
    if (longint'(DONE_VALUE) >= (longint'(1) << WIDTH)) begin : g_bad_done
        $error("frame_timer: DONE_VALUE does not fit in WIDTH bits");
    end

    localparam logic [WIDTH-1:0] END_V  = WIDTH'(END_COUNT);
    localparam logic [WIDTH-1:0] DONE_V = WIDTH'(DONE_VALUE);

    timer_state_t     r_state;
    timer_state_t     w_state_nx;
    logic [WIDTH-1:0] r_un_time;
    logic [WIDTH-1:0] w_time_nx;
    logic             r_stop;
    logic             r_running;
    logic             r_tick;
    logic             w_tick_nx;
    logic             w_fp;
    logic             w_pause;

`ifdef FRAME_TIMER_PAUSE_EN
    assign w_pause = pause_sign;
`else
    logic w_unused_pause;
    assign w_unused_pause = pause_sign;
    assign w_pause        = 1'b0;
`endif

    frame_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .new_frame(new_frame),
        .fp       (w_fp)
    );

    always_comb begin
        w_state_nx = r_state;
        w_time_nx  = r_un_time;
        w_tick_nx  = 1'b0;
        unique case (r_state)
            HALTED: begin
                w_time_nx = '0;
                if (start_sign) w_state_nx = RUN;
            end
            RUN: begin
                if (abort_sign) begin
                    w_state_nx = HALTED;
                    w_time_nx  = '0;
                end else if (r_un_time == END_V) begin
                    w_state_nx = DONE;
                    w_time_nx  = DONE_V;
                end else if (w_pause) begin
                    // a frame pulse landing with pause is dropped
                    w_state_nx = PAUSE;
                end else if (w_fp) begin
                    w_time_nx = r_un_time + WIDTH'(1);
                    w_tick_nx = 1'b1;
                end
            end
            PAUSE: begin
                if (abort_sign) begin
                    w_state_nx = HALTED;
                    w_time_nx  = '0;
                end else if (!w_pause) begin
                    w_state_nx = RUN;
                end
            end
            DONE: begin
                w_time_nx = DONE_V;
                if (abort_sign) begin
                    w_state_nx = HALTED;
                    w_time_nx  = '0;
                end
            end
            default: begin
                w_state_nx = HALTED;
                w_time_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= HALTED;
            r_un_time <= '0;
            r_stop    <= 1'b0;
            r_running <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_un_time <= w_time_nx;
            r_stop    <= (w_state_nx == DONE);
            r_running <= (w_state_nx == RUN);
            r_tick    <= w_tick_nx;
        end
    end

    assign stop_sign  = r_stop;
    assign running    = r_running;
    assign frame_tick = r_tick;
    assign un_time    = r_un_time;

endmodule

// File: tb/tb_frame_timer.sv
// Directed self-checking bench for frame_timer (WIDTH=8, END=20, DONE=25).
// Expected pause results depend on whether FRAME_TIMER_PAUSE_EN is defined.
module tb_frame_timer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_sign = 1'b0;
    logic       pause_sign = 1'b0;
    logic       abort_sign = 1'b0;
    logic       new_frame = 1'b0;
    logic       stop_sign;
    logic       running;
    logic       frame_tick;
    logic [7:0] un_time;

    int vectors = 0;
    int miscompares = 0;
    int tick_total = 0;
    int seen20_total = 0;
    int bad_total = 0;

    frame_timer #(
        .WIDTH(8),
        .END_COUNT(20),
        .DONE_VALUE(25),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start_sign(start_sign),
        .pause_sign(pause_sign),
        .abort_sign(abort_sign),
        .new_frame (new_frame),
        .stop_sign (stop_sign),
        .running   (running),
        .frame_tick(frame_tick),
        .un_time   (un_time)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_tick === 1'b1) tick_total++;

    always @(negedge clk) begin
        if (un_time === 8'd20) seen20_total++;
        if (un_time > 8'd20 && un_time !== 8'd25) bad_total++;
    end

    task automatic frame();
        @(negedge clk);
        new_frame = 1'b1;
        repeat (3) @(negedge clk);
        new_frame = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start_sign = 1'b1;
        @(negedge clk);
        start_sign = 1'b0;
    endtask

    task automatic abort_pulse();
        @(negedge clk);
        abort_sign = 1'b1;
        @(negedge clk);
        abort_sign = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if (un_time !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_un_time: got %0d want 0", un_time);
        end
        vectors++;
        if ({stop_sign, running, frame_tick} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 000",
                     {stop_sign, running, frame_tick});
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (un_time !== 8'd0 || running !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got t=%0d run=%b want 0/0",
                     un_time, running);
        end
    endtask

    // fp lands in the same cycle start is sampled in HALTED
    task automatic test_start_coincident();
        @(negedge clk);
        new_frame = 1'b1;
        repeat (3) @(posedge clk);
        #1 start_sign = 1'b1;
        @(posedge clk);
        #1 start_sign = 1'b0;
        repeat (2) @(negedge clk);
        new_frame = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (un_time !== 8'd0 || running !== 1'b1) begin
            miscompares++;
            $display("FAIL start_fp_coincident: got t=%0d run=%b want 0/1",
                     un_time, running);
        end
    endtask

    task automatic test_count();
        int t0;
        t0 = tick_total;
        frames(10);
        vectors++;
        if (un_time !== 8'd10) begin
            miscompares++;
            $display("FAIL count10: got %0d want 10", un_time);
        end
        vectors++;
        if (tick_total - t0 !== 10) begin
            miscompares++;
            $display("FAIL tick_count: got %0d want 10", tick_total - t0);
        end
        vectors++;
        if (running !== 1'b1 || stop_sign !== 1'b0) begin
            miscompares++;
            $display("FAIL count_flags: got run=%b stop=%b want 1/0",
                     running, stop_sign);
        end
    endtask

    task automatic test_abort_run();
        frames(2);
        vectors++;
        if (un_time !== 8'd12) begin
            miscompares++;
            $display("FAIL count12: got %0d want 12", un_time);
        end
        abort_pulse();
        vectors++;
        if ({un_time, running, stop_sign} !== {8'd0, 2'b00}) begin
            miscompares++;
            $display("FAIL abort_run: got t=%0d run=%b stop=%b want 0/0/0",
                     un_time, running, stop_sign);
        end
        start_pulse();
        frames(3);
        vectors++;
        if (un_time !== 8'd3) begin
            miscompares++;
            $display("FAIL restart3: got %0d want 3", un_time);
        end
        abort_pulse();
    endtask

    task automatic test_pause();
        logic [7:0] e_hold, e_rel, e_coin;
`ifdef FRAME_TIMER_PAUSE_EN
        e_hold = 8'd5;
        e_rel  = 8'd7;
        e_coin = 8'd7;
`else
        e_hold = 8'd9;
        e_rel  = 8'd11;
        e_coin = 8'd12;
`endif
        start_pulse();
        frames(5);
        vectors++;
        if (un_time !== 8'd5) begin
            miscompares++;
            $display("FAIL pause_pre5: got %0d want 5", un_time);
        end
        @(negedge clk);
        pause_sign = 1'b1;
        frames(4);
        vectors++;
        if (un_time !== e_hold) begin
            miscompares++;
            $display("FAIL pause_hold: got %0d want %0d", un_time, e_hold);
        end
        @(negedge clk);
        pause_sign = 1'b0;
        frames(2);
        vectors++;
        if (un_time !== e_rel) begin
            miscompares++;
            $display("FAIL pause_release: got %0d want %0d", un_time, e_rel);
        end
        @(negedge clk);
        new_frame = 1'b1;
        repeat (3) @(posedge clk);
        #1 pause_sign = 1'b1;
        repeat (2) @(negedge clk);
        new_frame = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (un_time !== e_coin) begin
            miscompares++;
            $display("FAIL pause_fp_coincident: got %0d want %0d",
                     un_time, e_coin);
        end
        pause_sign = 1'b0;
        abort_pulse();
    endtask

    task automatic test_done();
        int s0, b0;
        s0 = seen20_total;
        b0 = bad_total;
        start_pulse();
        frames(25);
        vectors++;
        if (un_time !== 8'd25 || stop_sign !== 1'b1 || running !== 1'b0) begin
            miscompares++;
            $display("FAIL done_latch: got t=%0d stop=%b run=%b want 25/1/0",
                     un_time, stop_sign, running);
        end
        vectors++;
        if (seen20_total - s0 !== 1) begin
            miscompares++;
            $display("FAIL end_dwell: got %0d cycles at 20 want 1",
                     seen20_total - s0);
        end
        frames(5);
        vectors++;
        if (un_time !== 8'd25 || stop_sign !== 1'b1) begin
            miscompares++;
            $display("FAIL done_hold: got t=%0d stop=%b want 25/1",
                     un_time, stop_sign);
        end
        vectors++;
        if (bad_total - b0 !== 0) begin
            miscompares++;
            $display("FAIL done_overrun: got %0d bad samples want 0",
                     bad_total - b0);
        end
        start_pulse();
        vectors++;
        if (un_time !== 8'd25 || stop_sign !== 1'b1) begin
            miscompares++;
            $display("FAIL done_start_ignored: got t=%0d stop=%b want 25/1",
                     un_time, stop_sign);
        end
        abort_pulse();
        vectors++;
        if ({un_time, running, stop_sign} !== {8'd0, 2'b00}) begin
            miscompares++;
            $display("FAIL abort_done: got t=%0d run=%b stop=%b want 0/0/0",
                     un_time, running, stop_sign);
        end
        start_pulse();
        frames(3);
        vectors++;
        if (un_time !== 8'd3) begin
            miscompares++;
            $display("FAIL restart_after_done: got %0d want 3", un_time);
        end
    endtask

    task automatic test_reset_midrun();
        frames(2);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        vectors++;
        if ({un_time, stop_sign, running, frame_tick} !== 11'd0) begin
            miscompares++;
            $display("FAIL async_reset: got t=%0d stop=%b run=%b tick=%b want 0",
                     un_time, stop_sign, running, frame_tick);
        end
        @(negedge clk);
        #2 reset_n = 1'b1;
        frames(3);
        vectors++;
        if (un_time !== 8'd0 || running !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_frames: got t=%0d run=%b want 0/0",
                     un_time, running);
        end
    endtask

    initial begin
        test_reset();
        test_start_coincident();
        test_count();
        test_abort_run();
        test_pause();
        test_done();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
